// File: rtl/reg_file.sv
// reg_file: architectural registers with rename tags; `define REG_COMMIT_BYPASS_EN forwards same-cycle commits to reads
module reg_file #(
  parameter int ROB_SIZE_WIDTH = 3,
  parameter int REG_NUM = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic                      issue_valid,
  input  logic [4:0]                issue_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  input  logic [4:0]                commit_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  input  logic [31:0]               commit_value,
  input  logic [4:0]                rs1,
  input  logic [4:0]                rs2,
  output logic [31:0]               rs1_value,
  output logic [31:0]               rs2_value,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic [ROB_SIZE_WIDTH-1:0] rs1_rob_id,
  output logic [ROB_SIZE_WIDTH-1:0] rs2_rob_id
);
  logic [31:0]               regs [REG_NUM];
  logic [REG_NUM-1:0]        busy;
  logic [ROB_SIZE_WIDTH-1:0] tag  [REG_NUM];
  logic                      hit1, hit2;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
        tag[i]  <= '0;
      end
    end else if (rdy) begin
      if (commit_rd != '0) regs[commit_rd] <= commit_value;
      for (int i = 1; i < REG_NUM; i++) begin
        if (clear) begin
          busy[i] <= 1'b0;
          tag[i]  <= '0;
        end else if (issue_valid && issue_rd == 5'(i)) begin
          busy[i] <= 1'b1;
          tag[i]  <= issue_rob_id;
        end else if (commit_rd == 5'(i) && tag[i] == commit_rob_id) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end
`ifdef REG_COMMIT_BYPASS_EN
  assign hit1 = rdy && commit_rd != '0 && rs1 == commit_rd && busy[rs1] && tag[rs1] == commit_rob_id;
  assign hit2 = rdy && commit_rd != '0 && rs2 == commit_rd && busy[rs2] && tag[rs2] == commit_rob_id;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif
  always_comb begin
    rs1_value  = hit1 ? commit_value : regs[rs1];
    rs2_value  = hit2 ? commit_value : regs[rs2];
    rs1_busy   = busy[rs1] && !hit1;
    rs2_busy   = busy[rs2] && !hit2;
    rs1_rob_id = rs1_busy ? tag[rs1] : '0;
    rs2_rob_id = rs2_busy ? tag[rs2] : '0;
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed vector table, hand sequences and randomized run against a register/rename model
module tb_reg_file;
  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1, clear = 1'b0, issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0, commit_rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  issue_rob_id = '0, commit_rob_id = '0;
  logic [31:0] commit_value = '0;
  logic [31:0] rs1_value, rs2_value;
  logic        rs1_busy, rs2_busy;
  logic [2:0]  rs1_rob_id, rs2_rob_id;
  int passed = 0, total = 0;
  logic [31:0] mv [32];
  logic        mb [32];
  logic [2:0]  mt [32];

  reg_file #(.ROB_SIZE_WIDTH(3), .REG_NUM(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_rob_id(issue_rob_id), .commit_rd(commit_rd),
    .commit_rob_id(commit_rob_id), .commit_value(commit_value), .rs1(rs1), .rs2(rs2),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_rob_id(rs1_rob_id), .rs2_rob_id(rs2_rob_id));

  always #5 clk = ~clk;

  typedef struct {
    logic iv; logic [4:0] ird; logic [2:0] itag;
    logic [4:0] crd; logic [2:0] ctag; logic [31:0] cval;
    logic clr; logic rd_y;
    logic [4:0] r1; logic [31:0] v1; logic b1; logic [2:0] t1;
    logic [4:0] r2; logic [31:0] v2; logic b2; logic [2:0] t2;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin mv[i] = '0; mb[i] = 1'b0; mt[i] = '0; end
  endtask

  // Spec-order model: commit first (using the old tag), then clear or issue overrides.
  task automatic model_update();
    if (!rdy) return;
    if (commit_rd != 0) begin
      mv[commit_rd] = commit_value;
      if (mt[commit_rd] == commit_rob_id) mb[commit_rd] = 1'b0;
    end
    if (clear) for (int i = 0; i < 32; i++) begin mb[i] = 1'b0; mt[i] = '0; end
    else if (issue_valid && issue_rd != 0) begin mb[issue_rd] = 1'b1; mt[issue_rd] = issue_rob_id; end
  endtask

  task automatic exp_read(input logic [4:0] r, output logic [31:0] v, output logic b, output logic [2:0] t);
    v = mv[r]; b = mb[r]; t = mb[r] ? mt[r] : 3'd0;
`ifdef REG_COMMIT_BYPASS_EN
    if (rdy && r != 0 && r == commit_rd && mb[r] && mt[r] == commit_rob_id) begin
      v = commit_value; b = 1'b0; t = 3'd0;
    end
`endif
  endtask

  task automatic check_model(input string tag_s);
    logic [31:0] v; logic b; logic [2:0] t;
    exp_read(rs1, v, b, t);
    chk({tag_s, " rs1_value"}, rs1_value, v);
    chk({tag_s, " rs1_busy"}, 32'(rs1_busy), 32'(b));
    chk({tag_s, " rs1_rob_id"}, 32'(rs1_rob_id), 32'(t));
    exp_read(rs2, v, b, t);
    chk({tag_s, " rs2_value"}, rs2_value, v);
    chk({tag_s, " rs2_busy"}, 32'(rs2_busy), 32'(b));
    chk({tag_s, " rs2_rob_id"}, 32'(rs2_rob_id), 32'(t));
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0; issue_rob_id = '0; commit_rd = '0;
    commit_rob_id = '0; commit_value = '0; clear = 1'b0; rdy = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    idle();
  endtask

  initial begin
    model_reset();
    vecs[0]  = '{1, 5, 3,  0, 0, 32'h0,        0, 1,  5, 32'h0,        1, 3,  0, 32'h0,  0, 0};
    vecs[1]  = '{0, 0, 0,  5, 3, 32'hDEADBEEF, 0, 1,  5, 32'hDEADBEEF, 0, 0,  7, 32'h0,  0, 0};
    vecs[2]  = '{1, 7, 1,  0, 0, 32'h0,        0, 1,  7, 32'h0,        1, 1,  0, 32'h0,  0, 0};
    vecs[3]  = '{1, 7, 2,  0, 0, 32'h0,        0, 1,  7, 32'h0,        1, 2,  5, 32'hDEADBEEF, 0, 0};
    vecs[4]  = '{0, 0, 0,  7, 1, 32'h11,       0, 1,  7, 32'h11,       1, 2,  0, 32'h0,  0, 0};
    vecs[5]  = '{1, 9, 6,  9, 4, 32'h55,       0, 1,  9, 32'h55,       1, 6,  7, 32'h11, 1, 2};
    vecs[6]  = '{1, 3, 1,  0, 0, 32'h0,        0, 1,  3, 32'h0,        1, 1,  9, 32'h55, 1, 6};
    vecs[7]  = '{1, 4, 2,  0, 0, 32'h0,        0, 1,  4, 32'h0,        1, 2,  3, 32'h0,  1, 1};
    vecs[8]  = '{1, 8, 5,  3, 0, 32'h77,       1, 1,  3, 32'h77,       0, 0,  8, 32'h0,  0, 0};
    vecs[9]  = '{0, 0, 0,  0, 0, 32'h0,        0, 1,  4, 32'h0,        0, 0,  7, 32'h11, 0, 0};
    vecs[10] = '{1, 10, 3, 10, 0, 32'hAA,      0, 0, 10, 32'h0,        0, 0,  9, 32'h55, 0, 0};
    vecs[11] = '{1, 0, 5,  0, 0, 32'h99,       0, 1,  0, 32'h0,        0, 0,  5, 32'hDEADBEEF, 0, 0};
    idle();
    rs1 = 5'd5;
    #2;
    chk("reset rs1_value", rs1_value, 32'h0);
    chk("reset rs1_busy", 32'(rs1_busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird; issue_rob_id = vecs[i].itag;
      commit_rd = vecs[i].crd; commit_rob_id = vecs[i].ctag; commit_value = vecs[i].cval;
      clear = vecs[i].clr; rdy = vecs[i].rd_y;
      step();
      rs1 = vecs[i].r1; rs2 = vecs[i].r2;
      #1;
      chk($sformatf("vec%0d rs1_value", i), rs1_value, vecs[i].v1);
      chk($sformatf("vec%0d rs1_busy", i), 32'(rs1_busy), 32'(vecs[i].b1));
      chk($sformatf("vec%0d rs1_rob_id", i), 32'(rs1_rob_id), 32'(vecs[i].t1));
      chk($sformatf("vec%0d rs2_value", i), rs2_value, vecs[i].v2);
      chk($sformatf("vec%0d rs2_busy", i), 32'(rs2_busy), 32'(vecs[i].b2));
      chk($sformatf("vec%0d rs2_rob_id", i), 32'(rs2_rob_id), 32'(vecs[i].t2));
    end
    // Same-cycle commit seen by a reader of that register.
    issue_valid = 1'b1; issue_rd = 5'd12; issue_rob_id = 3'd3;
    step();
    commit_rd = 5'd12; commit_rob_id = 3'd3; commit_value = 32'h1234; rs1 = 5'd12;
    #1;
`ifdef REG_COMMIT_BYPASS_EN
    chk("bypass rs1_value", rs1_value, 32'h1234);
    chk("bypass rs1_busy", 32'(rs1_busy), 32'h0);
    chk("bypass rs1_rob_id", 32'(rs1_rob_id), 32'h0);
`else
    chk("nobypass rs1_value", rs1_value, 32'h0);
    chk("nobypass rs1_busy", 32'(rs1_busy), 32'h1);
    chk("nobypass rs1_rob_id", 32'(rs1_rob_id), 32'h3);
`endif
    step();
    rs1 = 5'd12;
    #1;
    chk("post commit x12 value", rs1_value, 32'h1234);
    chk("post commit x12 busy", 32'(rs1_busy), 32'h0);
    // Mid-run asynchronous reset with x5 busy.
    issue_valid = 1'b1; issue_rd = 5'd5; issue_rob_id = 3'd2;
    step();
    rs1 = 5'd5; rs2 = 5'd12;
    #1;
    chk("pre-reset x5 busy", 32'(rs1_busy), 32'h1);
    rst = 1'b0;
    #1;
    model_reset();
    chk("async reset x5 value", rs1_value, 32'h0);
    chk("async reset x5 busy", 32'(rs1_busy), 32'h0);
    chk("async reset x5 tag", 32'(rs1_rob_id), 32'h0);
    chk("async reset x12 value", rs2_value, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    rs1 = 5'd5;
    #1;
    chk("after reset x5 value", rs1_value, 32'h0);
    chk("after reset x5 busy", 32'(rs1_busy), 32'h0);
    // Randomized traffic on a small register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      rdy = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 19) == 0);
      issue_valid = $urandom_range(0, 1);
      issue_rd = 5'($urandom_range(0, 7));
      issue_rob_id = 3'($urandom);
      commit_rd = 5'($urandom_range(0, 7));
      commit_rob_id = $urandom_range(0, 1) ? mt[commit_rd] : 3'($urandom);
      commit_value = $urandom;
      rs1 = $urandom_range(0, 1) ? commit_rd : 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      #1;
      check_model($sformatf("rand%0d", n));
      @(posedge clk);
      model_update();
      @(negedge clk);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
